// File: rtl/lc3b_mem_port_pkg.sv
// Shared types and sizing helpers for the LC-3b memory access port.
package lc3b_mem_port_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } lc3b_memport_state_e;

    function automatic int lane_bits(input int dw);
        return $clog2(dw / 8);
    endfunction

    // A zero MAX_WAIT still needs a one-bit counter so the register exists.
    function automatic int wait_bits(input int max_wait);
        return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
    endfunction

endpackage

// File: rtl/lc3b_mem_port_lane_steer.sv
// Byte-lane steering: lane enables and load extraction for the access in flight,
// plus store-data replication for the request being captured.
module lc3b_lane_steer
    import lc3b_mem_port_pkg::*;
#(
    parameter int DW = 16,
    localparam int LB = lane_bits(DW),
    localparam int NL = DW / 8
) (
    input  logic          byte_i,
    input  logic [LB-1:0] lane_i,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          st_byte_i,
    input  logic [DW-1:0] st_wdata_i,
    output logic [NL-1:0] be_o,
    output logic [DW-1:0] wdata_o,
    output logic [DW-1:0] rdata_o
);

    always_comb begin
        be_o    = '1;
        rdata_o = mem_rdata_i;
        wdata_o = st_byte_i ? {NL{st_wdata_i[7:0]}} : st_wdata_i;
        if (byte_i) begin
            be_o          = '0;
            be_o[lane_i]  = 1'b1;
            rdata_o       = '0;
            rdata_o[7:0]  = mem_rdata_i[int'(lane_i) * 8 +: 8];
        end
    end

endmodule

// File: rtl/lc3b_mem_port.sv
// Registered MAR/MDR memory access unit with wait-state timeout and byte-lane steering.
// Optional misaligned-word rejection: define LC3B_MEMPORT_ALIGN_CHECK_EN.
module lc3b_mem_port
    import lc3b_mem_port_pkg::*;
#(
    parameter int DW       = 16,
    parameter int AW       = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            req_read_i,
    input  logic            req_write_i,
    input  logic            req_byte_i,
    input  logic [AW-1:0]   req_addr_i,
    input  logic [DW-1:0]   req_wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            err_o,
    output logic [DW-1:0]   rdata_o,
    output logic [AW-1:0]   mem_address_o,
    output logic [DW-1:0]   mem_wdata_o,
    output logic            mem_read_o,
    output logic            mem_write_o,
    output logic [DW/8-1:0] mem_byte_enable_o,
    input  logic [DW-1:0]   mem_rdata_i,
    input  logic            mem_resp_i
);

    localparam int LB = lane_bits(DW);
    localparam int NL = DW / 8;
    localparam int CW = wait_bits(MAX_WAIT);
    localparam logic [CW-1:0] CNT_SAT = '1;

    lc3b_memport_state_e state_q, state_d;
    logic [AW-1:0] mar_q, mar_d;
    logic [DW-1:0] mdr_q, mdr_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          byte_q, byte_d;
    logic          write_q, write_d;
    logic          err_q, err_d;
    logic [LB-1:0] lane_q, lane_d;
    logic [CW-1:0] wait_q, wait_d;

    logic [NL-1:0] lane_be;
    logic [DW-1:0] st_wdata;
    logic [DW-1:0] ld_data;
    logic          timeout;

    lc3b_lane_steer #(.DW(DW)) u_steer (
        .byte_i      (byte_q),
        .lane_i      (lane_q),
        .mem_rdata_i (mem_rdata_i),
        .st_byte_i   (req_byte_i),
        .st_wdata_i  (req_wdata_i),
        .be_o        (lane_be),
        .wdata_o     (st_wdata),
        .rdata_o     (ld_data)
    );

    // Timeout fires on the ACCESS cycle whose increment would reach MAX_WAIT.
    assign timeout = (MAX_WAIT != 0) && ((int'(wait_q) + 1) >= MAX_WAIT);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            rdata_q <= '0;
            byte_q  <= 1'b0;
            write_q <= 1'b0;
            err_q   <= 1'b0;
            lane_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            rdata_q <= rdata_d;
            byte_q  <= byte_d;
            write_q <= write_d;
            err_q   <= err_d;
            lane_q  <= lane_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mar_d   = mar_q;
        mdr_d   = mdr_q;
        rdata_d = rdata_q;
        byte_d  = byte_q;
        write_d = write_q;
        err_d   = err_q;
        lane_d  = lane_q;
        wait_d  = wait_q;
        unique case (state_q)
            IDLE: begin
                if (req_read_i || req_write_i) begin
                    mar_d   = req_byte_i ? req_addr_i : {req_addr_i[AW-1:LB], {LB{1'b0}}};
                    mdr_d   = st_wdata;
                    byte_d  = req_byte_i;
                    lane_d  = req_addr_i[LB-1:0];
                    write_d = !req_read_i;
                    err_d   = 1'b0;
                    state_d = ACCESS;
`ifdef LC3B_MEMPORT_ALIGN_CHECK_EN
                    if (!req_byte_i && (req_addr_i[LB-1:0] != '0)) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
`endif
                end
            end
            ACCESS: begin
                if (mem_resp_i) begin
                    if (!write_q) begin
                        rdata_d = ld_data;
                    end
                    err_d   = 1'b0;
                    state_d = RESP;
                end else begin
                    if (wait_q != CNT_SAT) begin
                        wait_d = wait_q + 1'b1;
                    end
                    if (timeout) begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                wait_d  = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o            = (state_q != IDLE);
    assign done_o            = (state_q == RESP);
    assign err_o             = (state_q == RESP) && err_q;
    assign rdata_o           = rdata_q;
    assign mem_address_o     = mar_q;
    assign mem_wdata_o       = mdr_q;
    assign mem_read_o        = (state_q == ACCESS) && !write_q;
    assign mem_write_o       = (state_q == ACCESS) && write_q;
    assign mem_byte_enable_o = (state_q == ACCESS) ? lane_be : '0;

endmodule

// File: tb/tb_lc3b_mem_port.sv
// Randomized self-checking bench for lc3b_mem_port (DW=32, AW=16, MAX_WAIT=4).
module tb_lc3b_mem_port;

    localparam int DW   = 32;
    localparam int AW   = 16;
    localparam int MAXW = 4;

    logic          clk;
    logic          reset;
    logic          reqRead;
    logic          reqWrite;
    logic          reqByte;
    logic [AW-1:0] reqAddr;
    logic [DW-1:0] reqWdata;
    logic          busy;
    logic          done;
    logic          err;
    logic [DW-1:0] rdata;
    logic [AW-1:0] memAddress;
    logic [DW-1:0] memWdata;
    logic          memRead;
    logic          memWrite;
    logic [3:0]    memByteEnable;
    logic [DW-1:0] memRdata;
    logic          memResp;

    int checkCount = 0;
    int errCount   = 0;
    logic [DW-1:0] modelRdata;

    lc3b_mem_port #(.DW(DW), .AW(AW), .MAX_WAIT(MAXW)) dut (
        .clk_i             (clk),
        .reset_i           (reset),
        .req_read_i        (reqRead),
        .req_write_i       (reqWrite),
        .req_byte_i        (reqByte),
        .req_addr_i        (reqAddr),
        .req_wdata_i       (reqWdata),
        .busy_o            (busy),
        .done_o            (done),
        .err_o             (err),
        .rdata_o           (rdata),
        .mem_address_o     (memAddress),
        .mem_wdata_o       (memWdata),
        .mem_read_o        (memRead),
        .mem_write_o       (memWrite),
        .mem_byte_enable_o (memByteEnable),
        .mem_rdata_i       (memRdata),
        .mem_resp_i        (memResp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One transaction: respAt is the ACCESS cycle (1-based) carrying mem_resp; 0 or >MAXW means never.
    task automatic applyStimulus(input bit isRead, input bit alsoWrite, input bit isByte,
                                 input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                                 input int respAt, input logic [DW-1:0] memData, input bit inject);
        logic [AW-1:0] expAddr;
        logic [DW-1:0] expWdata;
        logic [3:0]    expBe;
        logic [DW-1:0] shifted;
        int            accessCycles;
        bit            expErr;

        expAddr      = isByte ? addr : {addr[AW-1:2], 2'b00};
        expWdata     = isByte ? {4{wd[7:0]}} : wd;
        expBe        = isByte ? (4'b0001 << addr[1:0]) : 4'b1111;
        expErr       = !(respAt >= 1 && respAt <= MAXW);
        accessCycles = expErr ? MAXW : respAt;
        if (isRead && !expErr) begin
            shifted    = memData >> (8 * int'(addr[1:0]));
            modelRdata = isByte ? {24'h0, shifted[7:0]} : memData;
        end

        @(negedge clk);
        reqRead  = isRead;
        reqWrite = !isRead || alsoWrite;
        reqByte  = isByte;
        reqAddr  = addr;
        reqWdata = wd;
        @(negedge clk);
        reqRead  = 1'b0;
        reqWrite = 1'b0;
        for (int k = 1; k <= accessCycles; k++) begin
            checkOutput("access_busy", busy, 1);
            checkOutput("access_done", done, 0);
            checkOutput("mem_read", memRead, isRead);
            checkOutput("mem_write", memWrite, !isRead);
            checkOutput("byte_enable", memByteEnable, expBe);
            checkOutput("mem_address", memAddress, expAddr);
            checkOutput("mem_wdata", memWdata, expWdata);
            memResp  = (k == respAt);
            memRdata = (k == respAt) ? memData : $urandom;
            if (inject && k == 2) begin
                reqRead  = 1'b1;
                reqWrite = 1'b1;
                reqByte  = ~isByte;
                reqAddr  = ~addr;
                reqWdata = ~wd;
            end else begin
                reqRead  = 1'b0;
                reqWrite = 1'b0;
            end
            @(negedge clk);
        end
        memResp  = 1'b0;
        reqRead  = 1'b0;
        reqWrite = 1'b0;
        checkOutput("resp_done", done, 1);
        checkOutput("resp_err", err, expErr);
        checkOutput("resp_busy", busy, 1);
        checkOutput("resp_strobes", {memRead, memWrite}, 0);
        checkOutput("resp_be", memByteEnable, 0);
        checkOutput("resp_rdata", rdata, modelRdata);
        @(negedge clk);
        checkOutput("idle_done", done, 0);
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_rdata", rdata, modelRdata);
    endtask

    initial begin
        reset    = 1'b1;
        reqRead  = 1'b0;
        reqWrite = 1'b0;
        reqByte  = 1'b0;
        reqAddr  = '0;
        reqWdata = '0;
        memRdata = '0;
        memResp  = 1'b0;
        modelRdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_err", err, 0);
        checkOutput("rst_strobes", {memRead, memWrite}, 0);
        checkOutput("rst_be", memByteEnable, 0);
        checkOutput("rst_addr", memAddress, 0);
        checkOutput("rst_wdata", memWdata, 0);
        checkOutput("rst_rdata", rdata, 0);
        reset = 1'b0;

        $display("[TB] directed transactions");
        applyStimulus(1, 0, 0, 16'h3005, 32'h0, 3, 32'hDEADBEEF, 0);
        applyStimulus(0, 0, 1, 16'h0102, 32'h000000A5, 2, 32'h0, 0);
        applyStimulus(1, 0, 1, 16'h0013, 32'h0, 1, 32'h8C123456, 0);
        applyStimulus(1, 0, 0, 16'h0200, 32'h0, 0, 32'h0, 0);
        applyStimulus(1, 0, 0, 16'h0204, 32'h0, 4, 32'h12345678, 0);
        applyStimulus(1, 1, 0, 16'h0300, 32'hFFFFFFFF, 2, 32'hCAFEF00D, 1);

        $display("[TB] reset during access");
        @(negedge clk);
        reqRead = 1'b1;
        reqByte = 1'b0;
        reqAddr = 16'h0040;
        @(negedge clk);
        reqRead = 1'b0;
        checkOutput("midrst_read_before", memRead, 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        modelRdata = '0;
        checkOutput("midrst_read", memRead, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_rdata", rdata, 0);
        @(negedge clk);
        checkOutput("midrst_done_after", done, 0);
        applyStimulus(1, 0, 0, 16'h0044, 32'h0, 2, 32'h0BADC0DE, 0);

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          AW'($urandom), $urandom, $urandom_range(0, MAXW + 1), $urandom,
                          1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errCount);
        $finish;
    end

endmodule
